// File: rtl/load_store_unit_pkg.sv
// Shared memory-stage definitions: access sizes, LSU state encoding and
// byte-lane helpers used by the load/store unit and its load aligner.
package rv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  lane_be = 4'b0001 << off;
      SIZE_H:  lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Size 3 is never legal; halves need an even address, words a 4-aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  store_lanes = {4{wdata[7:0]}};
      SIZE_H:  store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request, data-memory and writeback signals of the load/store unit.
// master = execute stage plus data memory; slave = the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
  // execute holds req_* stable until then. dm_req and its payload stay stable
  // until the edge where dm_ack is high; dm_rdata is valid in that same cycle.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_be;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output dm_ack, dm_rdata,
    input  req_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  wb_valid, wb_rd, wb_data, err_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  dm_ack, dm_rdata,
    output req_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output wb_valid, wb_rd, wb_data, err_misalign
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extract: picks the addressed byte/half out of a full
// memory word and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SIZE_B:  load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Blocking memory stage: accepts one load/store, runs a req/ack access to data
// memory, and returns one extended writeback beat for loads.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output lsu_state_t         dbg_state
);

  lsu_state_t        state;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [1:0]        lat_off;
  logic [4:0]        lat_rd;

  logic              dm_req_q;
  logic              dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic [3:0]        dm_be_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              err_q;
  logic [DATA_W-1:0] load_data;

  lsu_load_align u_load_align (
    .rdata       (bus.dm_rdata),
    .size        (lat_size),
    .off         (lat_off),
    .is_unsigned (lat_unsigned),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'd0;
      lat_rd       <= 5'd0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_be_q      <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we       <= bus.req_we;
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_off      <= bus.req_addr[1:0];
            lat_rd       <= bus.req_rd;
            if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
              err_q <= 1'b1;
            end else begin
              state      <= MEM;
              dm_req_q   <= 1'b1;
              dm_we_q    <= bus.req_we;
              dm_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              dm_wdata_q <= store_lanes(bus.req_size, bus.req_wdata);
              dm_be_q    <= bus.req_we ? lane_be(bus.req_size, bus.req_addr[1:0]) : 4'b1111;
            end
          end
        end
        MEM: begin
          if (bus.dm_ack) begin
            dm_req_q <= 1'b0;
            if (lat_we) begin
              state <= IDLE;
            end else begin
              state     <= RESP;
              wb_data_q <= load_data;
            end
          end
        end
        RESP: begin
          // x0 is hard-wired zero, so its writeback strobe is suppressed.
          wb_valid_q <= (lat_rd != 5'd0);
          wb_rd_q    <= lat_rd;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.dm_req       = dm_req_q;
  assign bus.dm_we        = dm_we_q;
  assign bus.dm_addr      = dm_addr_q;
  assign bus.dm_wdata     = dm_wdata_q;
  assign bus.dm_be        = dm_be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.err_misalign = err_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drivers push expected memory requests,
// writebacks and error pulses into queues; a monitor pops and compares them.
module tb_load_store_unit;
  import rv_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  lsu_state_t dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic [68:0] exp_mem_q[$];  // {we, be, addr, wdata (0 for loads)}
  logic [36:0] exp_wb_q[$];   // {rd, data}
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic        prev_req = 1'b0;
    logic [68:0] e;
    logic [36:0] w;
    logic        x;
    forever begin
      @(negedge clk);
      if (bus.dm_req && !prev_req) begin
        if (exp_mem_q.size() == 0) check("dm_req_unexpected", 69'(bus.dm_req), 69'd0);
        else begin
          e = exp_mem_q.pop_front();
          check("dm_request", {bus.dm_we, bus.dm_be, bus.dm_addr,
                               bus.dm_we ? bus.dm_wdata : 32'h0}, e);
        end
      end
      prev_req = bus.dm_req;
      if (bus.wb_valid) begin
        if (exp_wb_q.size() == 0) check("wb_unexpected", 69'(bus.wb_valid), 69'd0);
        else begin
          w = exp_wb_q.pop_front();
          check("wb_beat", 69'({bus.wb_rd, bus.wb_data}), 69'(w));
        end
      end
      if (bus.err_misalign) begin
        if (exp_err_q.size() == 0) check("err_unexpected", 69'(bus.err_misalign), 69'd0);
        else begin
          x = exp_err_q.pop_front();
          check("err_misalign", 69'(bus.err_misalign), 69'(x));
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_accept_timeout", 69'(bus.req_ready), 69'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic mem_respond(input int waits, input logic [31:0] rdata);
    int n = 0;
    @(negedge clk);
    while (!bus.dm_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dm_req) check("dm_req_timeout", 69'(bus.dm_req), 69'd1);
    repeat (waits) @(negedge clk);
    bus.dm_rdata = rdata;
    bus.dm_ack   = 1'b1;
    @(posedge clk);
    #1 bus.dm_ack = 1'b0;
  endtask

  task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] lanes);
    exp_mem_q.push_back({1'b1, be, addr & 32'hFFFF_FFFC, lanes});
    issue(1'b1, size, 1'b0, addr, wdata, 5'd0);
    mem_respond(0, 32'h0);
    @(negedge clk);
    check("store_ready_again", 69'(bus.req_ready), 69'd1);
    check("store_no_wb", 69'(bus.wb_valid), 69'd0);
  endtask

  task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    exp_mem_q.push_back({1'b0, 4'b1111, addr & 32'hFFFF_FFFC, 32'h0});
    if (rd != 5'd0) exp_wb_q.push_back({rd, exp});
    issue(1'b0, size, uns, addr, 32'h0, rd);
    mem_respond(0, rdata);
    @(negedge clk);
    check("load_wb_early", 69'(bus.wb_valid), 69'd0);
    @(negedge clk);
    check("load_wb_lat3", 69'(bus.wb_valid), 69'(rd != 5'd0));
    @(negedge clk);
  endtask

  task automatic run_bad(input logic [1:0] size, input logic [31:0] addr);
    exp_err_q.push_back(1'b1);
    issue(1'b0, size, 1'b0, addr, 32'h0, 5'd3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("bad_no_dm_req", 69'(bus.dm_req), 69'd0);
      check("bad_ready", 69'(bus.req_ready), 69'd1);
      if (c == 1) check("bad_err_pulse", 69'(bus.err_misalign), 69'd1);
      if (c == 2) check("bad_err_one_cycle", 69'(bus.err_misalign), 69'd0);
    end
  endtask

  initial begin
    int req_cnt;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_rd       = 5'd0;
    bus.dm_ack       = 1'b0;
    bus.dm_rdata     = 32'h0;
    fork
      monitor_loop();
    join_none

    // Clock/reset block
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 69'(dbg_state), 69'(IDLE));
    check("rst_req_ready", 69'(bus.req_ready), 69'd1);
    check("rst_outputs", 69'({bus.dm_req, bus.dm_we, bus.dm_be, bus.wb_valid, bus.err_misalign}), 69'd0);
    check("rst_buses", 69'({bus.dm_addr, bus.dm_wdata}), 69'd0);
    check("rst_wb", 69'({bus.wb_rd, bus.wb_data}), 69'd0);

    // Stores: byte lane 3, half lanes 3:2, full word
    run_store(SIZE_B, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    run_store(SIZE_H, 32'h62, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    run_store(SIZE_W, 32'h70, 32'h0123_4567, 4'b1111, 32'h0123_4567);

    // Loads with zero-wait memory
    run_load(SIZE_B, 1'b0, 32'h22, 5'd5,  32'h0080_0000, 32'hFFFF_FF80);
    run_load(SIZE_B, 1'b1, 32'h22, 5'd5,  32'h0080_0000, 32'h0000_0080);
    run_load(SIZE_B, 1'b1, 32'h51, 5'd12, 32'h1234_5678, 32'h0000_0056);
    run_load(SIZE_B, 1'b0, 32'h53, 5'd13, 32'h9A00_0000, 32'hFFFF_FF9A);
    run_load(SIZE_H, 1'b1, 32'h42, 5'd14, 32'h8001_1234, 32'h0000_8001);
    run_load(SIZE_H, 1'b0, 32'h40, 5'd15, 32'h8001_F234, 32'hFFFF_F234);
    run_load(SIZE_W, 1'b0, 32'h80, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Half load with three wait cycles before ack
    exp_mem_q.push_back({1'b0, 4'b1111, 32'h40, 32'h0});
    exp_wb_q.push_back({5'd7, 32'hFFFF_8001});
    issue(1'b0, SIZE_H, 1'b0, 32'h42, 32'h0, 5'd7);
    req_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 5) req_cnt += int'(bus.dm_req);
      if (c == 4) begin
        bus.dm_rdata = 32'h8001_1234;
        bus.dm_ack   = 1'b1;
      end
      if (c == 5) begin
        bus.dm_ack = 1'b0;
        check("wait_wb_early", 69'(bus.wb_valid), 69'd0);
      end
      if (c == 6) check("wait_wb_lat6", 69'(bus.wb_valid), 69'd1);
    end
    check("wait_dm_req_held", 69'(req_cnt), 69'd4);
    @(negedge clk);

    // Misaligned / illegal requests
    run_bad(SIZE_W, 32'h06);
    run_bad(SIZE_H, 32'h43);
    run_bad(2'd3,   32'h40);

    // Reset while waiting in MEM, late ack afterwards
    exp_mem_q.push_back({1'b0, 4'b1111, 32'h30, 32'h0});
    issue(1'b0, SIZE_W, 1'b0, 32'h30, 32'h0, 5'd9);
    @(negedge clk);
    check("mid_rst_in_mem", 69'(bus.dm_req), 69'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dm_req", 69'(bus.dm_req), 69'd0);
    check("mid_rst_ready", 69'(bus.req_ready), 69'd1);
    @(negedge clk);
    bus.dm_rdata = 32'h5555_5555;
    bus.dm_ack   = 1'b1;
    @(posedge clk);
    #1 bus.dm_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("late_ack_no_wb", 69'(bus.wb_valid), 69'd0);
      check("late_ack_no_req", 69'(bus.dm_req), 69'd0);
      check("late_ack_ready", 69'(bus.req_ready), 69'd1);
    end

    // Load to x0, then a store accepted in the IDLE-entry cycle
    exp_mem_q.push_back({1'b0, 4'b1111, 32'h08, 32'h0});
    exp_mem_q.push_back({1'b1, 4'b0010, 32'h08, 32'h3C3C_3C3C});
    issue(1'b0, SIZE_W, 1'b0, 32'h08, 32'h0, 5'd0);
    @(negedge clk);
    bus.dm_rdata     = 32'h1122_3344;
    bus.dm_ack       = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = SIZE_B;
    bus.req_addr     = 32'h09;
    bus.req_wdata    = 32'h0000_003C;
    bus.req_rd       = 5'd0;
    bus.req_valid    = 1'b1;
    check("b2b_busy_mem", 69'(bus.req_ready), 69'd0);
    @(posedge clk);
    #1 bus.dm_ack = 1'b0;
    @(negedge clk);
    check("b2b_busy_resp", 69'(bus.req_ready), 69'd0);
    @(negedge clk);
    check("b2b_idle_entry", 69'(bus.req_ready), 69'd1);
    check("x0_no_wb", 69'(bus.wb_valid), 69'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_store_dm_req", 69'(bus.dm_req), 69'd1);
    bus.dm_ack = 1'b1;
    @(posedge clk);
    #1 bus.dm_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Final report
    check("mem_q_drained", 69'(exp_mem_q.size()), 69'd0);
    check("wb_q_drained", 69'(exp_wb_q.size()), 69'd0);
    check("err_q_drained", 69'(exp_err_q.size()), 69'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
